// File: rtl/fp_add_normalize_round.sv
// fp_add_normalize_round
//   Normalization and rounding stage that follows the mantissa adder in the
//   single-precision add/sub datapath. It takes the raw signed-magnitude sum,
//   the larger exponent and the guard/round/sticky bits, and produces a packed
//   IEEE-754 result. A multi-cycle FSM (IDLE -> NORM -> ROUND -> OUT) does one
//   left shift per cycle. Valid/ready handshakes on both sides decouple the
//   adder from this data-dependent latency.
//
//   Ports
//     clk_in, rst_in     clock, synchronous active-high reset
//     valid_in/ready_out upstream handshake (ready only in IDLE)
//     sign_in            result sign
//     exponent_in        larger operand exponent
//     mantissa_in        raw sum, bit 24 = carry, bit 23 = hidden
//     grs_in             {guard, round, sticky}
//     valid_out/ready_in downstream handshake
//     floating_out       {sign, exponent, fraction}
//     overflow_out       result became infinity
//     underflow_out      result is denormal or flushed to zero
//
//   Build option
//     FP_ADD_NORM_DENORM_EN  defined: produce denormals when the exponent runs
//                            out during normalization; undefined: flush to zero.
module fp_add_normalize_round #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  sign_in,
  input  logic [EXPO_WIDTH-1:0] exponent_in,
  input  logic [MENT_WIDTH+1:0] mantissa_in,
  input  logic [2:0]            grs_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] floating_out,
  output logic                  overflow_out,
  output logic                  underflow_out
);

  localparam int MW = MENT_WIDTH + 2;   // carry + hidden + fraction
  localparam int EW = EXPO_WIDTH + 1;   // one spare bit to catch exponent overflow
  localparam logic [EW-1:0] EXP_INF = {1'b0, {EXPO_WIDTH{1'b1}}};
  localparam logic [EW-1:0] EXP_ONE = EW'(1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [EW-1:0]         exp_q, exp_d;
  logic [MW-1:0]         mant_q, mant_d;
  logic                  g_q, r_q, s_q, g_d, r_d, s_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  vld_q, vld_d;

  logic [EW-1:0]         exp_inc;
  logic [MENT_WIDTH+1:0] rnd_sum;
  logic [EW-1:0]         rnd_exp;
  logic [MENT_WIDTH-1:0] rnd_frac;
  logic                  rnd_hidden;

  // Round-to-nearest-even increment decision.
  function automatic logic rne_up(input logic lsb, input logic g, input logic r,
                                  input logic s);
    return g & (r | s | lsb);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pack(input logic s,
                                                 input logic [EXPO_WIDTH-1:0] e,
                                                 input logic [MENT_WIDTH-1:0] f);
    return {s, e, f};
  endfunction

  // Saturated infinity with the given sign.
  function automatic logic [DATA_WIDTH-1:0] pack_inf(input logic s);
    return {s, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
  endfunction

  assign ready_out     = (state_q == IDLE);
  assign valid_out     = vld_q;
  assign floating_out  = res_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;

  assign exp_inc = exp_q + EXP_ONE;

  // Rounding datapath, only consumed in ROUND.
  always_comb begin
    rnd_sum = {1'b0, mant_q[MENT_WIDTH:0]}
            + {{(MENT_WIDTH+1){1'b0}}, rne_up(mant_q[0], g_q, r_q, s_q)};
    if (rnd_sum[MENT_WIDTH+1]) begin
      // 1.111..1 rounded up to 10.000..0: renormalize by bumping the exponent.
      rnd_frac   = '0;
      rnd_hidden = 1'b1;
      rnd_exp    = exp_inc;
    end else begin
      rnd_frac   = rnd_sum[MENT_WIDTH-1:0];
      rnd_hidden = rnd_sum[MENT_WIDTH];
      rnd_exp    = exp_q;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          sign_d = sign_in;
          exp_d  = {1'b0, exponent_in};
          mant_d = mantissa_in;
          {g_d, r_d, s_d} = grs_in;
          if (exponent_in == {EXPO_WIDTH{1'b1}}) begin
            // Inf/NaN operands bypass normalization with payload intact.
            res_d   = pack(sign_in, {EXPO_WIDTH{1'b1}}, mantissa_in[MENT_WIDTH-1:0]);
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            state_d = OUT;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mant_q[MW-1]) begin
          mant_d = {1'b0, mant_q[MW-1:1]};
          g_d    = mant_q[0];
          r_d    = g_q;
          s_d    = r_q | s_q;
          exp_d  = exp_inc;
          if (exp_inc >= EXP_INF) begin
            res_d   = pack_inf(sign_q);
            ovf_d   = 1'b1;
            unf_d   = 1'b0;
            state_d = OUT;
          end else begin
            state_d = ROUND;
          end
        end else if ((mant_q == '0) && !(g_q | r_q | s_q)) begin
          // Exact cancellation always yields +0.
          res_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = OUT;
        end else if (mant_q[MENT_WIDTH]) begin
          state_d = ROUND;
        end else if (exp_q > EXP_ONE) begin
          mant_d = {1'b0, mant_q[MENT_WIDTH-1:0], g_q};
          g_d    = r_q;
          r_d    = 1'b0;
          exp_d  = exp_q - EXP_ONE;
        end else begin
`ifdef FP_ADD_NORM_DENORM_EN
          state_d = ROUND;
`else
          res_d   = pack(sign_q, {EXPO_WIDTH{1'b0}}, {MENT_WIDTH{1'b0}});
          ovf_d   = 1'b0;
          unf_d   = 1'b1;
          state_d = OUT;
`endif
        end
      end
      ROUND: begin
        if (rnd_exp >= EXP_INF) begin
          res_d = pack_inf(sign_q);
          ovf_d = 1'b1;
          unf_d = 1'b0;
        end else begin
          // Without the hidden bit the value is denormal: exponent field 0.
          // A denormal that rounds into the hidden bit keeps exp 1.
          res_d = pack(sign_q,
                       rnd_hidden ? rnd_exp[EXPO_WIDTH-1:0] : {EXPO_WIDTH{1'b0}},
                       rnd_frac);
          ovf_d = 1'b0;
          unf_d = !rnd_hidden;
        end
        state_d = OUT;
      end
      OUT: begin
        // valid_out rises one cycle after entering OUT; leave only once the
        // result has actually been presented and taken.
        if (vld_q && ready_in) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end else begin
          vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Working datapath registers
  always_ff @(posedge clk_in) begin
    sign_q <= sign_d;
    exp_q  <= exp_d;
    mant_q <= mant_d;
    g_q    <= g_d;
    r_q    <= r_d;
    s_q    <= s_d;
  end

endmodule

// File: tb/tb_fp_add_normalize_round.sv
// Directed bench for fp_add_normalize_round: hand-computed vectors covering
// carry, left shifts, RNE ties, overflow, cancellation, denormal/flush,
// Inf/NaN bypass, output stall and reset during normalization.
module tb_fp_add_normalize_round;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        ready_out;
  logic        sign_in;
  logic [7:0]  exponent_in;
  logic [24:0] mantissa_in;
  logic [2:0]  grs_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] floating_out;
  logic        overflow_out;
  logic        underflow_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_in = ~clk_in;

  fp_add_normalize_round dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .sign_in      (sign_in),
    .exponent_in  (exponent_in),
    .mantissa_in  (mantissa_in),
    .grs_in       (grs_in),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .floating_out (floating_out),
    .overflow_out (overflow_out),
    .underflow_out(underflow_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, expv);
  endtask

  // Drive one operand (called #1 after a rising edge), wait for the result,
  // check it, optionally stall downstream for 'hold' cycles, then accept it.
  task automatic do_op(input string tag, input logic s, input logic [7:0] e,
                       input logic [24:0] m, input logic [2:0] g, input int lat_exp,
                       input logic [31:0] f_exp, input logic ovf_exp,
                       input logic unf_exp, input int hold);
    int lat;
    check({tag, "_rdy_in"}, 32'(ready_out), 32'd1);
    sign_in     = s;
    exponent_in = e;
    mantissa_in = m;
    grs_in      = g;
    valid_in    = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    lat = 0;
    while (!valid_out && lat < 60) begin
      @(posedge clk_in); #1;
      lat++;
    end
    if (!valid_out) begin
      check({tag, "_timeout"}, 32'(valid_out), 32'd1);
      return;
    end
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    check({tag, "_res"}, floating_out, f_exp);
    check({tag, "_ovf"}, 32'(overflow_out), 32'(ovf_exp));
    check({tag, "_unf"}, 32'(underflow_out), 32'(unf_exp));
    check({tag, "_busy"}, 32'(ready_out), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_in); #1;
      check({tag, "_hold_vld"}, 32'(valid_out), 32'd1);
      check({tag, "_hold_res"}, floating_out, f_exp);
      check({tag, "_hold_rdy"}, 32'(ready_out), 32'd0);
    end
    ready_in = 1'b1;
    @(posedge clk_in); #1;
    ready_in = 1'b0;
    check({tag, "_vld_drop"}, 32'(valid_out), 32'd0);
    check({tag, "_rdy_back"}, 32'(ready_out), 32'd1);
  endtask

  initial begin
    rst_in      = 1'b1;
    valid_in    = 1'b0;
    ready_in    = 1'b0;
    sign_in     = 1'b0;
    exponent_in = '0;
    mantissa_in = '0;
    grs_in      = '0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    check("rst_rdy", 32'(ready_out), 32'd1);
    check("rst_vld", 32'(valid_out), 32'd0);
    check("rst_res", floating_out, 32'h0);
    check("rst_flags", {30'd0, overflow_out, underflow_out}, 32'd0);

    // Carry: 1.1b x2 -> exp 0x81, frac 0x400000
    do_op("carry", 1'b0, 8'h80, 25'h1800000, 3'b000, 3, 32'h40C00000, 1'b0, 1'b0, 0);
    // Three left shifts: exp 0x85 -> 0x82
    do_op("lshift3", 1'b0, 8'h85, 25'h0100000, 3'b000, 6, 32'h41000000, 1'b0, 1'b0, 0);
    // Tie with odd LSB rounds up to even
    do_op("tie_odd", 1'b0, 8'h7F, 25'h0800001, 3'b100, 3, 32'h3F800002, 1'b0, 1'b0, 0);
    // Tie with even LSB stays
    do_op("tie_even", 1'b0, 8'h7F, 25'h0800002, 3'b100, 3, 32'h3F800002, 1'b0, 1'b0, 0);
    // Above half rounds up, negative sign kept
    do_op("gt_half", 1'b1, 8'h80, 25'h0C00000, 3'b110, 3, 32'hC0400001, 1'b0, 1'b0, 0);
    // Carry shifts a 1 into guard; odd LSB after shift makes it round up
    do_op("carry_rnd", 1'b0, 8'h80, 25'h1800003, 3'b000, 3, 32'h40C00002, 1'b0, 1'b0, 0);
    // Round-up carries out at exp 0xFE -> infinity
    do_op("rnd_inf", 1'b0, 8'hFE, 25'h0FFFFFF, 3'b110, 3, 32'h7F800000, 1'b1, 1'b0, 0);
    // Carry at exp 0xFE -> infinity directly from NORM
    do_op("carry_inf", 1'b1, 8'hFE, 25'h1800000, 3'b000, 2, 32'hFF800000, 1'b1, 1'b0, 0);
    // Exact cancellation -> +0 regardless of sign
    do_op("zero", 1'b1, 8'h40, 25'h0000000, 3'b000, 2, 32'h00000000, 1'b0, 1'b0, 0);
    // Inf/NaN bypass keeps payload
    do_op("nan", 1'b1, 8'hFF, 25'h0400001, 3'b000, 1, 32'hFFC00001, 1'b0, 1'b0, 0);
`ifdef FP_ADD_NORM_DENORM_EN
    // One shift to exp 1, then denormal with fraction 0x000800
    do_op("denorm", 1'b0, 8'h02, 25'h0000400, 3'b000, 4, 32'h00000800, 1'b0, 1'b1, 0);
`else
    // One shift to exp 1, then flush to zero
    do_op("denorm", 1'b0, 8'h02, 25'h0000400, 3'b000, 3, 32'h00000000, 1'b0, 1'b1, 0);
`endif
    // Downstream stall for 5 cycles
    do_op("stall", 1'b0, 8'h80, 25'h1800000, 3'b000, 3, 32'h40C00000, 1'b0, 1'b0, 5);

    // Reset while in NORM discards the operand
    sign_in     = 1'b0;
    exponent_in = 8'h85;
    mantissa_in = 25'h0100000;
    grs_in      = 3'b000;
    valid_in    = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    check("mid_busy", 32'(ready_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check("mid_rst_rdy", 32'(ready_out), 32'd1);
    check("mid_rst_vld", 32'(valid_out), 32'd0);
    check("mid_rst_res", floating_out, 32'h0);
    repeat (8) begin
      @(posedge clk_in); #1;
      check("mid_rst_quiet", 32'(valid_out), 32'd0);
    end
    // Recovery after reset
    do_op("after_rst", 1'b0, 8'h85, 25'h0100000, 3'b000, 6, 32'h41000000, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
